// File: rtl/ld_cmd_sequencer.sv
// Queued command master for the LD_Project register/indicator block: drives selects/inp, samples indicators.
// Optional build macro LD_SEQ_CHECK_EN adds WRITE readback checking (resp_err, err_count).
module ld_cmd_sequencer #(
   parameter int DEPTH  = 4,
   parameter int HOLD   = 1,
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [4:0] cmd_data,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       s3,
   output logic [4:0] inp,
   input  logic [4:0] fgt,
   input  logic [4:0] frt,
   input  logic [4:0] fgc,
   input  logic [4:0] frc,
   input  logic       fgp,
   input  logic       frp,
   output logic       busy,
   output logic       resp_valid,
   output logic [1:0] resp_op,
   output logic [4:0] resp_fgt,
   output logic [4:0] resp_frt,
   output logic [4:0] resp_fgc,
   output logic [4:0] resp_frc,
   output logic       resp_fgp,
`ifdef LD_SEQ_CHECK_EN
   output logic       resp_frp,
   output logic       resp_err,
   output logic [7:0] err_count
`else
   output logic       resp_frp
`endif
);

   localparam int AW   = $clog2(DEPTH);
   localparam int PW   = AW + 1;
   localparam int CMAX = (HOLD > SETTLE) ? HOLD : SETTLE;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [PW-1:0] DEPTH_P     = PW'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SETTLE, ST_SAMPLE} state_t;

   state_t          state;
   logic [6:0]      mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr, count, count_next;
   logic [CW-1:0]   cnt;
   logic [1:0]      op_q;
   logic            push, pop;
   logic [6:0]      head;
`ifdef LD_SEQ_CHECK_EN
   logic [4:0]      data_q;
   logic            err;

   function automatic logic write_mismatch(input logic [4:0] d, input logic [4:0] gt, input logic [4:0] rt,
                                           input logic [4:0] gc, input logic [4:0] rc,
                                           input logic gp, input logic rp);
      return (gt != d) || (rt != ~d) || (gc != ~d) || (rc != d) || (gp != ^d) || (rp != ~^d);
   endfunction

   assign err = (op_q == 2'b01) && write_mismatch(data_q, fgt, frt, fgc, frc, fgp, frp);
`endif

   assign push       = cmd_valid && cmd_ready;
   assign count      = wr_ptr - rd_ptr;
   assign pop        = (state == ST_IDLE) && (count != {PW{1'b0}});
   assign count_next = count + {{(PW-1){1'b0}}, push} - {{(PW-1){1'b0}}, pop};
   assign head       = mem[rd_ptr[AW-1:0]];
   assign s3         = 1'b0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         op_q       <= 2'b00;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         s0         <= 1'b0;
         s1         <= 1'b0;
         s2         <= 1'b0;
         inp        <= 5'd0;
         resp_valid <= 1'b0;
         resp_op    <= 2'b00;
         resp_fgt   <= 5'd0;
         resp_frt   <= 5'd0;
         resp_fgc   <= 5'd0;
         resp_frc   <= 5'd0;
         resp_fgp   <= 1'b0;
         resp_frp   <= 1'b0;
`ifdef LD_SEQ_CHECK_EN
         data_q     <= 5'd0;
         resp_err   <= 1'b0;
         err_count  <= 8'd0;
`endif
      end else begin
         wr_ptr     <= wr_ptr + {{(PW-1){1'b0}}, push};
         rd_ptr     <= rd_ptr + {{(PW-1){1'b0}}, pop};
         // a pop in this cycle frees a slot, but ready only rises on the next cycle
         cmd_ready  <= (count_next != DEPTH_P);
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               s0 <= 1'b0;
               s1 <= 1'b0;
               s2 <= 1'b0;
               if (pop) begin
                  op_q  <= head[6:5];
`ifdef LD_SEQ_CHECK_EN
                  data_q <= head[4:0];
`endif
                  inp   <= head[4:0];
                  s0    <= (head[6:5] == 2'b01);
                  s1    <= (head[6:5] == 2'b10);
                  s2    <= (head[6:5] == 2'b11);
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_DRIVE;
               end else begin
                  busy  <= (count_next != {PW{1'b0}});
               end
            end
            ST_DRIVE: begin
               busy <= 1'b1;
               if (cnt == HOLD_LAST) begin
                  s0    <= 1'b0;
                  s1    <= 1'b0;
                  s2    <= 1'b0;
                  cnt   <= '0;
                  state <= (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_SETTLE: begin
               busy <= 1'b1;
               if (cnt == SETTLE_LAST) begin
                  cnt   <= '0;
                  state <= ST_SAMPLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_SAMPLE: begin
               resp_valid <= 1'b1;
               resp_op    <= op_q;
               resp_fgt   <= fgt;
               resp_frt   <= frt;
               resp_fgc   <= fgc;
               resp_frc   <= frc;
               resp_fgp   <= fgp;
               resp_frp   <= frp;
`ifdef LD_SEQ_CHECK_EN
               resp_err   <= err;
               if (err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
`endif
               busy       <= (count_next != {PW{1'b0}});
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ld_cmd_sequencer.sv
// Scoreboard bench for ld_cmd_sequencer with a tiny LD_Project indicator model; covers LD_SEQ_CHECK_EN when defined.
module tb_ld_cmd_sequencer;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid, cmd_ready, s0, s1, s2, s3, busy, resp_valid;
   logic [1:0] cmd_op, resp_op;
   logic [4:0] cmd_data, inp, fgt, frt, fgc, frc;
   logic [4:0] resp_fgt, resp_frt, resp_fgc, resp_frc;
   logic fgp, frp, resp_fgp, resp_frp;
`ifdef LD_SEQ_CHECK_EN
   logic resp_err;
   logic [7:0] err_count;
   int exp_errs = 0;
`endif

   always #5 clk = ~clk;

   ld_cmd_sequencer #(.DEPTH(4), .HOLD(1), .SETTLE(1)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .s0(s0), .s1(s1), .s2(s2), .s3(s3), .inp(inp),
      .fgt(fgt), .frt(frt), .fgc(fgc), .frc(frc), .fgp(fgp), .frp(frp),
      .busy(busy), .resp_valid(resp_valid), .resp_op(resp_op),
      .resp_fgt(resp_fgt), .resp_frt(resp_frt), .resp_fgc(resp_fgc), .resp_frc(resp_frc),
      .resp_fgp(resp_fgp),
`ifdef LD_SEQ_CHECK_EN
      .resp_frp(resp_frp), .resp_err(resp_err), .err_count(err_count)
`else
      .resp_frp(resp_frp)
`endif
   );

   // LD_Project stand-in: a WRITE latches inp, indicators reflect the stored word
   logic [4:0] ld_q = 5'd0;
   logic fault = 1'b0;
   always @(posedge clk) if (s0) ld_q <= inp;
   assign fgt = ld_q;
   assign frt = ~ld_q;
   assign fgc = ~ld_q;
   assign frc = ld_q;
   assign fgp = (^ld_q) ^ fault;
   assign frp = ~(^ld_q);

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  data;
      logic [21:0] ind;
      int          cyc;
      logic        err;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int checks = 0, failures = 0, cyc = 0, last_resp = 0;
   logic [4:0] last_wr = 5'd0;
   int sel_cyc = 0;
   logic [2:0] sel_seen = 3'b000;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [21:0] ind_of(input logic [4:0] d, input logic f);
      return {d, ~d, ~d, d, (^d) ^ f, ~(^d)};
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [4:0] d, output int stalls);
      exp_t e;
      int p;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      stalls    = 0;
      while (!cmd_ready && stalls < 100) begin
         @(negedge clk);
         stalls++;
      end
      if (!cmd_ready) begin
         chk("accept_timeout", int'(cmd_ready), 1);
      end else begin
         p = cyc + 1;
         if (op == 2'b01) last_wr = d;
         e.op   = op;
         e.data = d;
         e.ind  = ind_of(last_wr, fault);
         e.err  = (op == 2'b01) && fault;
         e.cyc  = ((p > last_resp) ? p : last_resp) + LAT;
         last_resp = e.cyc;
         sbq.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sbq.size(), 0);
      @(negedge clk);
   endtask

   // response monitor: pops the scoreboard on every resp_valid and tracks select activity
   always @(negedge clk) begin
      if (rst) begin
         sel_cyc  = 0;
         sel_seen = 3'b000;
`ifdef LD_SEQ_CHECK_EN
         exp_errs = 0;
`endif
      end else begin
         if (resp_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_resp", int'(resp_valid), 0);
            end else begin
               mon_e = sbq.pop_front();
               chk("resp_op", int'(resp_op), int'(mon_e.op));
               chk("resp_ind", int'({resp_fgt, resp_frt, resp_fgc, resp_frc, resp_fgp, resp_frp}), int'(mon_e.ind));
               chk("resp_inp", int'(inp), int'(mon_e.data));
               chk("resp_cycle", cyc, mon_e.cyc);
               chk("sel_seen", int'(sel_seen), (mon_e.op == 2'b00) ? 0 : (1 << (mon_e.op - 2'b01)));
               chk("sel_cycles", sel_cyc, (mon_e.op == 2'b00) ? 0 : 1);
               chk("s3_low", int'(s3), 0);
`ifdef LD_SEQ_CHECK_EN
               chk("resp_err", int'(resp_err), int'(mon_e.err));
               if (mon_e.err && exp_errs < 255) exp_errs++;
               chk("err_count", int'(err_count), exp_errs);
`endif
            end
            sel_cyc  = 0;
            sel_seen = 3'b000;
         end
         if (s0 | s1 | s2) begin
            sel_cyc++;
            sel_seen = sel_seen | {s2, s1, s0};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, sum, first_stall;
      logic [1:0] bops [6];
      logic [4:0] bdat [6];
      bops = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11};
      bdat = '{5'b00110, 5'b11000, 5'b00001, 5'b11001, 5'b01110, 5'b10000};
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 5'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", int'(cmd_ready), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_outs", int'({resp_valid, s0, s1, s2, s3, inp, resp_op}), 0);
      chk("reset_resp", int'({resp_fgt, resp_frt, resp_fgc, resp_frc, resp_fgp, resp_frp}), 0);

      // single WRITE
      send(2'b01, 5'b11111, st);
      drain();

      // back-to-back WRITE / SEL1 / SEL2
      sum = 0;
      send(2'b01, 5'b10101, st); sum += st;
      send(2'b10, 5'b00000, st); sum += st;
      send(2'b11, 5'b00000, st); sum += st;
      chk("b2b_no_stall", sum, 0);
      drain();

      // fill the FIFO behind a busy FSM
      send(2'b10, 5'b00011, st);
      first_stall = -1;
      for (int i = 0; i < 6; i++) begin
         send(bops[i], bdat[i], st);
         if (st != 0 && first_stall < 0) first_stall = i;
      end
      chk("burst_accept_before_stall", first_stall, 4);
      drain();

      // op 00: no select, data still driven
      send(2'b00, 5'b00111, st);
      drain();

      // reset during DRIVE of WRITE 01010 with two more queued
      send(2'b10, 5'b00001, st);
      send(2'b01, 5'b01010, st);
      send(2'b01, 5'b00110, st);
      send(2'b11, 5'b00010, st);
      @(negedge clk);
      @(negedge clk);
      chk("mid_drive_s0", int'(s0), 1);
      chk("mid_drive_inp", int'(inp), 5'b01010);
      #1 rst = 1'b1;
      #1 chk("rst_s0_drop", int'(s0), 0);
      sbq.delete();
      last_resp = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_ready", int'(cmd_ready), 1);
      repeat (12) @(negedge clk);

      // corrupted parity indicator, then a clean WRITE
      fault = 1'b1;
      send(2'b01, 5'b10101, st);
      drain();
      fault = 1'b0;
      send(2'b01, 5'b10101, st);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
